// File: rtl/interp_pkg.sv
// Shared definitions for the vertical interpolation window buffer:
// default geometry, FSM state encoding and the beats-per-row helper.
package interp_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int IN_PIX_DEF  = 8;
    localparam int ROW_PIX_DEF = 15;
    localparam int TAPS_DEF    = 8;
    localparam int PAD_TOP_DEF = 3;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_VALID = 2'd1,
        ST_WAIT  = 2'd2
    } win_state_t;

    // Number of input beats needed to cover one window row.
    function automatic int beats_per_row(input int row_pix, input int in_pix);
        return (row_pix + in_pix - 1) / in_pix;
    endfunction

endpackage

// File: rtl/interp_row_assembler.sv
// Row assembler: collects IN_PIX-pixel beats into one ROW_PIX-pixel row.
// Ports: clock/reset/sof, beat input (in_valid/in_data), ready, pop
// (consume pending row), pending flag and the assembled row.
module row_assembler
    import interp_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int IN_PIX  = IN_PIX_DEF,
    parameter int ROW_PIX = ROW_PIX_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sof,
    input  logic                     in_valid,
    input  logic [IN_PIX*PIX_W-1:0]  in_data,
    input  logic                     pop,
    output logic                     ready,
    output logic                     pending,
    output logic [ROW_PIX*PIX_W-1:0] row
);

    localparam int BEATS = beats_per_row(ROW_PIX, IN_PIX);
    localparam int BW    = $clog2(BEATS + 1);

    logic [BW-1:0] beat_cnt;
    logic          take;

    assign ready = !pending;
    assign take  = in_valid && !pending;

    always_ff @(posedge clock) begin
        if (reset || sof) begin
            beat_cnt <= '0;
            pending  <= 1'b0;
            row      <= '0;
        end else if (take) begin
            // Beat k owns pixels k*IN_PIX onward; pixels past ROW_PIX
            // simply have no destination and are dropped.
            for (int p = 0; p < ROW_PIX; p++) begin
                if (beat_cnt == BW'(p / IN_PIX)) begin
                    row[p*PIX_W +: PIX_W] <=
                        in_data[(p % IN_PIX)*PIX_W +: PIX_W];
                end
            end
            if (beat_cnt == BW'(BEATS - 1)) begin
                beat_cnt <= '0;
                pending  <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end else if (pop) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interp_window_buffer.sv
// Sliding TAPS-row window for the vertical subpixel filters, with
// optional top-edge replication and valid/ready flow control.
// Ports: clock, reset, sof, pad_en, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data (row 0 oldest in LSBs), out_first.
module interp_window_buffer
    import interp_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int IN_PIX  = IN_PIX_DEF,
    parameter int ROW_PIX = ROW_PIX_DEF,
    parameter int TAPS    = TAPS_DEF,
    parameter int PAD_TOP = PAD_TOP_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sof,
    input  logic                          pad_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_PIX*PIX_W-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TAPS*ROW_PIX*PIX_W-1:0] out_data,
    output logic                          out_first
);

    localparam int RW  = ROW_PIX * PIX_W;
    localparam int HW  = $clog2(TAPS + 1);
    localparam int PCW = $clog2(PAD_TOP + 2);

    win_state_t         state;
    win_state_t         nstate;
    logic [RW-1:0]      row_data;
    logic               row_ready;
    logic               row_pending;
    logic               shift;
    logic               pop;
    logic [HW-1:0]      rows_held;
    logic               pad_pend;
    logic [PCW-1:0]     pad_cnt;
    logic               first_flag;
    logic [TAPS*RW-1:0] window;

    row_assembler #(
        .PIX_W   (PIX_W),
        .IN_PIX  (IN_PIX),
        .ROW_PIX (ROW_PIX)
    ) u_asm (
        .clock    (clock),
        .reset    (reset),
        .sof      (sof),
        .in_valid (in_valid),
        .in_data  (in_data),
        .pop      (pop),
        .ready    (row_ready),
        .pending  (row_pending),
        .row      (row_data)
    );

    // The first row of a padded frame stays pending until it has been
    // shifted in PAD_TOP+1 times, which also holds in_ready low.
    assign pop = shift && !(pad_pend && pad_cnt != PCW'(PAD_TOP));

    assign in_ready  = row_ready && !reset;
    assign out_data  = window;
    assign out_first = out_valid && first_flag;

    always_ff @(posedge clock) begin
        if (reset || sof) begin
            state <= ST_FILL;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_FILL: begin
                if (shift && rows_held == HW'(TAPS - 1)) begin
                    nstate = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_ready && !row_pending) begin
                    nstate = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (row_pending) begin
                    nstate = ST_VALID;
                end
            end
            default: nstate = ST_FILL;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        shift     = 1'b0;
        unique case (state)
            ST_FILL:  shift = row_pending;
            ST_VALID: begin
                out_valid = 1'b1;
                shift     = out_ready && row_pending;
            end
            ST_WAIT:  shift = row_pending;
            default:  shift = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || sof) begin
            window     <= '0;
            rows_held  <= '0;
            pad_pend   <= !reset && pad_en;
            pad_cnt    <= '0;
            first_flag <= !reset;
        end else begin
            if (shift) begin
                window <= {row_data, window[TAPS*RW-1:RW]};
                if (rows_held != HW'(TAPS)) begin
                    rows_held <= rows_held + 1'b1;
                end
                if (pad_pend) begin
                    if (pad_cnt == PCW'(PAD_TOP)) begin
                        pad_pend <= 1'b0;
                        pad_cnt  <= '0;
                    end else begin
                        pad_cnt <= pad_cnt + 1'b1;
                    end
                end
            end
            if (out_valid && out_ready) begin
                first_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interp_window_buffer.sv
// Self-checking bench for interp_window_buffer: fill, padding,
// backpressure, WAIT state and sof abort, with an expected-window queue.
module tb_interp_window_buffer;

    localparam int PIX_W   = 8;
    localparam int IN_PIX  = 8;
    localparam int ROW_PIX = 15;
    localparam int TAPS    = 8;
    localparam int PAD_TOP = 3;
    localparam int IW      = IN_PIX * PIX_W;
    localparam int RW      = ROW_PIX * PIX_W;
    localparam int OW      = TAPS * RW;

    logic          clock;
    logic          reset;
    logic          sof;
    logic          pad_en;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_first;

    int n_vec;
    int n_err;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] expw;

    interp_window_buffer #(
        .PIX_W   (PIX_W),
        .IN_PIX  (IN_PIX),
        .ROW_PIX (ROW_PIX),
        .TAPS    (TAPS),
        .PAD_TOP (PAD_TOP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sof       (sof),
        .pad_en    (pad_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Row r pixel p = r*16+p; pixel slots past ROW_PIX carry junk.
    function automatic logic [IW-1:0] beat_of(input int r, input int k);
        logic [IW-1:0] b;
        int p;
        b = '0;
        for (int j = 0; j < IN_PIX; j++) begin
            p = k * IN_PIX + j;
            b[j*PIX_W +: PIX_W] = (p < ROW_PIX) ? 8'(r * 16 + p) : 8'hFF;
        end
        return b;
    endfunction

    function automatic logic [RW-1:0] row_of(input int r);
        logic [RW-1:0] v;
        for (int p = 0; p < ROW_PIX; p++) begin
            v[p*PIX_W +: PIX_W] = 8'(r * 16 + p);
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] win_of(input int rs[TAPS]);
        logic [OW-1:0] w;
        for (int i = 0; i < TAPS; i++) begin
            w[i*RW +: RW] = row_of(rs[i]);
        end
        return w;
    endfunction

    function automatic logic [OW-1:0] win_seq(input int first);
        int rs[TAPS];
        for (int i = 0; i < TAPS; i++) rs[i] = first + i;
        return win_of(rs);
    endfunction

    // Caller is aligned just after a rising edge.
    task automatic send_beat(input logic [IW-1:0] d);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL beat_accept: in_ready=0 for 50 cycles, want 1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_row(input int r);
        send_beat(beat_of(r, 0));
        send_beat(beat_of(r, 1));
    endtask

    task automatic do_sof(input logic pe);
        sof    = 1'b1;
        pad_en = pe;
        @(posedge clock);
        #1;
        sof    = 1'b0;
        pad_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 0", in_ready);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== '0 || out_first !== 1'b0) begin
            n_err++;
            $display("FAIL rst_state: valid=%b ready=%b first=%b data_nz=%b want 0 1 0 0",
                     out_valid, in_ready, out_first, |out_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_window(input string name, input logic first);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else if (out_valid !== 1'b1 || out_data !== exp_q[0] ||
                     out_first !== first) begin
            n_err++;
            $display("FAIL %s: valid=%b first=%b row0=%h row7=%h want 1 %b %h %h",
                     name, out_valid, out_first, out_data[RW-1:0],
                     out_data[OW-1 -: RW], first, exp_q[0][RW-1:0],
                     exp_q[0][OW-1 -: RW]);
        end
    endtask

    task automatic consume(input string name, input logic first);
        out_ready = 1'b1;
        @(negedge clock);
        check_window(name, first);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic fill_rows_0_7(input string name);
        for (int r = 0; r < TAPS; r++) send_row(r);
        exp_q.push_back(win_seq(0));
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early: out_valid=%b want 0", name, out_valid);
        end
        @(negedge clock);
        check_window(name, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic test_fill;
        do_sof(1'b0);
        fill_rows_0_7("fill");
    endtask

    task automatic test_backpressure;
        send_row(8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                (exp_q.size() != 0 && out_data !== exp_q[0])) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: ready=%b valid=%b want 0 1, data stable",
                         i, in_ready, out_valid);
            end
        end
        @(posedge clock);
        #1;
        consume("bp_accept", 1'b1);
        exp_q.push_back(win_seq(1));
        @(negedge clock);
        check_window("bp_shift", 1'b0);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wait;
        consume("wait_take", 1'b0);
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_state: out_valid=%b want 0", out_valid);
        end
        @(posedge clock);
        #1;
        send_row(9);
        exp_q.push_back(win_seq(2));
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_early: out_valid=%b want 0", out_valid);
        end
        @(negedge clock);
        check_window("wait_row9", 1'b0);
        @(posedge clock);
        #1;
    endtask

    task automatic test_sof_abort;
        send_beat(beat_of(10, 0));
        sof      = 1'b1;
        in_valid = 1'b1;
        in_data  = beat_of(10, 1);
        @(posedge clock);
        #1;
        sof      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_err++;
            $display("FAIL sof_clear: valid=%b ready=%b data_nz=%b want 0 1 0",
                     out_valid, in_ready, |out_data);
        end
        @(posedge clock);
        #1;
        fill_rows_0_7("sof_refill");
        consume("sof_take", 1'b1);
    endtask

    task automatic test_pad;
        int rs[TAPS];
        do_sof(1'b1);
        send_row(0);
        for (int i = 0; i < PAD_TOP + 1; i++) begin
            @(negedge clock);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL pad_hold[%0d]: in_ready=%b want 0", i, in_ready);
            end
        end
        @(negedge clock);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pad_release: in_ready=%b want 1", in_ready);
        end
        @(posedge clock);
        #1;
        for (int r = 1; r <= 4; r++) send_row(r);
        rs = '{0, 0, 0, 0, 1, 2, 3, 4};
        expw = win_of(rs);
        exp_q.push_back(expw);
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pad_early: out_valid=%b want 0", out_valid);
        end
        @(negedge clock);
        check_window("pad_window", 1'b1);
        @(posedge clock);
        #1;
        consume("pad_take", 1'b1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d windows left, want 0", exp_q.size());
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        sof       = 1'b0;
        pad_en    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_fill();
        test_backpressure();
        test_wait();
        test_sof_abort();
        test_pad();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
